// File: rtl/fb_arb_pkg.sv
// Shared types, slot map and defaults for the frame buffer arbiter.
package fb_arb_pkg;

    typedef enum logic [1:0] {IDLE, PIX_RD, PIX_WAIT, PIX_WR} clientState_t;
    typedef enum logic {PIX, ENG} grant_t;

    localparam logic [1:0] PH_DISP0 = 2'd0;
    localparam logic [1:0] PH_CLI0  = 2'd1;
    localparam logic [1:0] PH_DISP1 = 2'd2;
    localparam logic [1:0] PH_CLI1  = 2'd3;

    localparam int NUM_PIXELS_DEF = 307200;

endpackage

// File: rtl/pixel_merge.sv
// Replaces one 2-bit pixel inside a packed 8-pixel word.
module pixel_merge (
    input  logic [15:0] word,
    input  logic [2:0]  idx,
    input  logic [1:0]  pix,
    output logic [15:0] merged
);

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_pix
            assign merged[2*gi+1:2*gi] = (idx == 3'(gi)) ? pix : word[2*gi+1:2*gi];
        end
    endgenerate

endmodule

// File: rtl/frame_buffer_arbiter.sv
// Slot scheduler for the packed 2bpp frame buffer: two display reads per 4-cycle
// round, the other two slots shared round-robin by the pixel loader and the engine.
module frame_buffer_arbiter
    import fb_arb_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int NUM_PIXELS = NUM_PIXELS_DEF
) (
    input  logic              mainClk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] dispAddr,
    output logic [DATA_W-1:0] dispData,
    output logic              dispValid,
    input  logic              pixReq,
    input  logic [18:0]       pixAddr,
    input  logic [1:0]        pixData,
    output logic              pixAck,
    input  logic              engReq,
    input  logic              engWrite,
    input  logic [ADDR_W-1:0] engAddr,
    input  logic [DATA_W-1:0] engWData,
    output logic              engAck,
    output logic [DATA_W-1:0] engRData,
    output logic              engRValid,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWData,
    output logic              memWe,
    output logic [3:0]        memMask,
    input  logic [DATA_W-1:0] memRData
);

    logic [1:0]        phase_q, phase_d;
    clientState_t      state_q, state_d;
    grant_t            lastGrant_q, lastGrant_d;
    logic [ADDR_W-1:0] pixWord_q, pixWord_d;
    logic [2:0]        pixIdx_q, pixIdx_d;
    logic [1:0]        pixVal_q, pixVal_d;
    logic [DATA_W-1:0] mergeBuf_q, mergeBuf_d;
    logic [ADDR_W-1:0] engAddr_q, engAddr_d;
    logic [DATA_W-1:0] engWData_q, engWData_d;
    logic              engWrite_q, engWrite_d;
    logic              pixAck_q, pixAck_d;
    logic              engAck_q, engAck_d;
    logic              dispValid_q, dispValid_d;
    logic              engRValid_q, engRValid_d;

    logic              disp_slot;
    logic              cli_slot;
    logic              pix_in_range;
    logic              pix_wins;
    logic [DATA_W-1:0] merged_word;

    assign disp_slot    = (phase_q == PH_DISP0) || (phase_q == PH_DISP1);
    assign cli_slot     = (phase_q == PH_CLI0) || (phase_q == PH_CLI1);
    assign pix_in_range = (32'(pixAddr) < NUM_PIXELS);

    pixel_merge u_merge (
        .word   (memRData),
        .idx    (pixIdx_q),
        .pix    (pixVal_q),
        .merged (merged_word)
    );

    always_comb begin
        phase_d     = phase_q + 2'd1;
        state_d     = state_q;
        lastGrant_d = lastGrant_q;
        pixWord_d   = pixWord_q;
        pixIdx_d    = pixIdx_q;
        pixVal_d    = pixVal_q;
        mergeBuf_d  = mergeBuf_q;
        engAddr_d   = engAddr_q;
        engWData_d  = engWData_q;
        engWrite_d  = engWrite_q;
        pixAck_d    = 1'b0;
        engAck_d    = 1'b0;
        pix_wins    = 1'b0;
        dispValid_d = disp_slot;
        engRValid_d = engAck_q && !engWrite_q;

        unique case (state_q)
            IDLE: begin
                // The owner of the next client slot is chosen during the display
                // slot before it, so the acks leave as registered pulses in that slot.
                if (disp_slot) begin
                    pix_wins = pixReq && (!engReq || (lastGrant_q == ENG));
                    if (pix_wins) begin
                        pixAck_d    = 1'b1;
                        lastGrant_d = PIX;
                        if (pix_in_range) begin
                            state_d   = PIX_RD;
                            pixWord_d = ADDR_W'(pixAddr[18:3]);
                            pixIdx_d  = pixAddr[2:0];
                            pixVal_d  = pixData;
                        end
                    end else if (engReq) begin
                        engAck_d    = 1'b1;
                        lastGrant_d = ENG;
                        engAddr_d   = engAddr;
                        engWData_d  = engWData;
                        engWrite_d  = engWrite;
                    end
                end
            end
            PIX_RD:   state_d = PIX_WAIT;
            PIX_WAIT: begin
                mergeBuf_d = merged_word;
                state_d    = PIX_WR;
            end
            PIX_WR:   state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        memAddr  = '0;
        memWData = '0;
        memWe    = 1'b0;
        if (disp_slot) begin
            memAddr = dispAddr;
        end else if (cli_slot) begin
            if (state_q == PIX_RD) begin
                memAddr = pixWord_q;
            end else if (state_q == PIX_WR) begin
                memAddr  = pixWord_q;
                memWData = mergeBuf_q;
                memWe    = 1'b1;
            end else if (engAck_q) begin
                memAddr  = engAddr_q;
                memWe    = engWrite_q;
                memWData = engWrite_q ? engWData_q : '0;
            end
        end
        memMask = memWe ? 4'b1111 : 4'b0000;
    end

    // Read data arrives the cycle after its slot, so it is steered straight from
    // memRData and qualified by the registered valid flags.
    assign dispValid = dispValid_q;
    assign dispData  = dispValid_q ? memRData : '0;
    assign engRValid = engRValid_q;
    assign engRData  = engRValid_q ? memRData : '0;
    assign pixAck    = pixAck_q;
    assign engAck    = engAck_q;

    always_ff @(posedge mainClk or posedge reset) begin
        if (reset) begin
            phase_q     <= PH_DISP0;
            state_q     <= IDLE;
            lastGrant_q <= ENG;
            pixWord_q   <= '0;
            pixIdx_q    <= '0;
            pixVal_q    <= '0;
            mergeBuf_q  <= '0;
            engAddr_q   <= '0;
            engWData_q  <= '0;
            engWrite_q  <= 1'b0;
            pixAck_q    <= 1'b0;
            engAck_q    <= 1'b0;
            dispValid_q <= 1'b0;
            engRValid_q <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            state_q     <= state_d;
            lastGrant_q <= lastGrant_d;
            pixWord_q   <= pixWord_d;
            pixIdx_q    <= pixIdx_d;
            pixVal_q    <= pixVal_d;
            mergeBuf_q  <= mergeBuf_d;
            engAddr_q   <= engAddr_d;
            engWData_q  <= engWData_d;
            engWrite_q  <= engWrite_d;
            pixAck_q    <= pixAck_d;
            engAck_q    <= engAck_d;
            dispValid_q <= dispValid_d;
            engRValid_q <= engRValid_d;
        end
    end

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Bench for frame_buffer_arbiter: directed vectors, corner sequences and a randomized
// run checked against a transaction-level memory/arbitration model.
module tb_frame_buffer_arbiter;

    logic        mainClk = 1'b0;
    logic        reset   = 1'b1;
    logic [15:0] dispAddr, dispData;
    logic        dispValid;
    logic        pixReq;
    logic [18:0] pixAddr;
    logic [1:0]  pixData;
    logic        pixAck;
    logic        engReq, engWrite, engAck, engRValid;
    logic [15:0] engAddr, engWData, engRData;
    logic [15:0] memAddr, memWData, memRData;
    logic        memWe;
    logic [3:0]  memMask;

    logic [15:0] mem [0:65535];
    logic        pre_we = 1'b0;
    logic [15:0] pre_addr = '0, pre_data = '0;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        logic [18:0] pa;
        logic [1:0]  pd;
        logic [15:0] init;
        logic        wr;
        logic [15:0] waddr;
        logic [15:0] wdata;
    } pix_vec_t;
    pix_vec_t pv [6];

    int          gk [4];
    int          gc [4];
    int          exp_k [4] = '{0, 1, 0, 1};
    int          exp_c [4] = '{1, 5, 7, 11};
    int          ng;
    logic [15:0] ref_mem [0:15];
    logic [15:0] exp_q [$];
    logic        s_p, s_e, s_w, exp_p, exp_e, lg_eng, rd_last;
    logic [18:0] s_pa;
    logic [1:0]  s_pd;
    logic [15:0] s_ea, s_ed, disp_exp;
    int          last_rmw;

    frame_buffer_arbiter dut (
        .mainClk   (mainClk),
        .reset     (reset),
        .dispAddr  (dispAddr),
        .dispData  (dispData),
        .dispValid (dispValid),
        .pixReq    (pixReq),
        .pixAddr   (pixAddr),
        .pixData   (pixData),
        .pixAck    (pixAck),
        .engReq    (engReq),
        .engWrite  (engWrite),
        .engAddr   (engAddr),
        .engWData  (engWData),
        .engAck    (engAck),
        .engRData  (engRData),
        .engRValid (engRValid),
        .memAddr   (memAddr),
        .memWData  (memWData),
        .memWe     (memWe),
        .memMask   (memMask),
        .memRData  (memRData)
    );

    always #5 mainClk = ~mainClk;

    // Synchronous SPRAM stand-in: read data valid the cycle after the address.
    always @(posedge mainClk) begin
        if (pre_we)
            mem[pre_addr] <= pre_data;
        else if (memWe && memMask == 4'b1111)
            mem[memAddr] <= memWData;
        memRData <= mem[memAddr];
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge mainClk);
        cyc++;
    endtask

    task automatic idle_inputs();
        dispAddr = '0; pixReq = 0; pixAddr = '0; pixData = '0;
        engReq = 0; engWrite = 0; engAddr = '0; engWData = '0;
    endtask

    // Reset for two cycles, preloading one memory word meanwhile; leaves cyc=0 at phase 0.
    task automatic do_reset(input logic [15:0] a, input logic [15:0] d);
        idle_inputs();
        reset = 1'b1;
        pre_addr = a; pre_data = d; pre_we = 1'b1;
        @(negedge mainClk);
        @(negedge mainClk);
        pre_we = 1'b0;
        chk("rst_pixAck", pixAck, 0);
        chk("rst_engAck", engAck, 0);
        chk("rst_dispValid", dispValid, 0);
        chk("rst_dispData", dispData, 0);
        chk("rst_engRValid", engRValid, 0);
        chk("rst_engRData", engRData, 0);
        chk("rst_memWe", memWe, 0);
        reset = 1'b0;
        cyc = 0;
    endtask

    initial begin
        pv[0] = '{19'd21,     2'b00, 16'hFFFF, 1'b1, 16'd2,     16'hF3FF};
        pv[1] = '{19'd24,     2'b10, 16'h0000, 1'b1, 16'd3,     16'h0002};
        pv[2] = '{19'd39,     2'b11, 16'h1234, 1'b1, 16'd4,     16'hD234};
        pv[3] = '{19'd307199, 2'b01, 16'hFFFF, 1'b1, 16'h95FF,  16'h7FFF};
        pv[4] = '{19'd307200, 2'b11, 16'h0000, 1'b0, 16'd0,     16'h0000};
        pv[5] = '{19'd524287, 2'b10, 16'h0000, 1'b0, 16'd0,     16'h0000};
        idle_inputs();

        // Display only.
        do_reset(16'h0010, 16'hA5A5);
        dispAddr = 16'h0010;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("disp_valid", dispValid, 32'(cyc % 2 == 1));
            if (cyc % 2 == 1) chk("disp_data", dispData, 16'hA5A5);
            chk("disp_we", memWe, 0);
        end

        // Pixel RMW and out-of-range vectors; an engine read probes when the FSM is idle again.
        foreach (pv[i]) begin
            do_reset(pv[i].waddr, pv[i].init);
            pixReq = 1; pixAddr = pv[i].pa; pixData = pv[i].pd;
            tick();
            chk("pix_ack", pixAck, 1);
            chk("pix_rd_we", memWe, 0);
            if (pv[i].wr) chk("pix_rd_addr", memAddr, pv[i].waddr);
            pixReq = 0; engReq = 1; engWrite = 0; engAddr = 16'd9;
            for (int c = 2; c <= 5; c++) begin
                tick();
                if (c == 2) chk("pix_ack_pulse", pixAck, 0);
                if (pv[i].wr && c == 3) begin
                    chk("pix_wr_we", memWe, 1);
                    chk("pix_wr_addr", memAddr, pv[i].waddr);
                    chk("pix_wr_data", memWData, pv[i].wdata);
                    chk("pix_wr_mask", memMask, 4'b1111);
                end else begin
                    chk("pix_no_we", memWe, 0);
                end
                chk("pix_eng_ack", engAck, 32'(c == (pv[i].wr ? 5 : 3)));
                if (engAck) engReq = 0;
            end
        end

        // Engine write then read back.
        do_reset(16'hFFFF, 16'h0000);
        engReq = 1; engWrite = 1; engAddr = 16'd7; engWData = 16'h1234;
        tick();
        chk("eng_wr_ack", engAck, 1);
        chk("eng_wr_we", memWe, 1);
        chk("eng_wr_addr", memAddr, 16'd7);
        chk("eng_wr_data", memWData, 16'h1234);
        engWrite = 0;
        tick();
        chk("eng_ack_gap", engAck, 0);
        tick();
        chk("eng_rd_ack", engAck, 1);
        chk("eng_rd_we", memWe, 0);
        chk("eng_rd_addr", memAddr, 16'd7);
        engReq = 0;
        tick();
        chk("eng_rvalid", engRValid, 1);
        chk("eng_rdata", engRData, 16'h1234);

        // Contention from reset.
        do_reset(16'hFFFF, 16'h0000);
        pixReq = 1; pixAddr = 19'd8; pixData = 2'b01;
        engReq = 1; engWrite = 0; engAddr = 16'd1;
        ng = 0;
        for (int c = 1; c <= 40 && ng < 4; c++) begin
            tick();
            chk("cont_disp_valid", dispValid, 32'(cyc % 2 == 1));
            if (pixAck || engAck) begin
                gk[ng] = pixAck ? 0 : 1;
                gc[ng] = cyc;
                ng++;
            end
        end
        chk("cont_grants", ng, 4);
        for (int i = 0; i < 4 && i < ng; i++) begin
            chk("cont_kind", gk[i], exp_k[i]);
            chk("cont_cycle", gc[i], exp_c[i]);
        end

        // Reset in PIX_WAIT abandons the write.
        do_reset(16'd2, 16'hFFFF);
        pixReq = 1; pixAddr = 19'd21; pixData = 2'b00;
        tick();
        chk("mid_pix_ack", pixAck, 1);
        pixReq = 0;
        tick();
        do_reset(16'hFFFF, 16'h0000);
        chk("mid_we0", memWe, 0);
        engReq = 1; engWrite = 0; engAddr = 16'd2;
        tick();
        chk("mid_we1", memWe, 0);
        chk("mid_eng_ack", engAck, 1);
        chk("mid_eng_addr", memAddr, 16'd2);
        engReq = 0;
        tick();
        chk("mid_rvalid", engRValid, 1);
        chk("mid_rdata", engRData, 16'hFFFF);
        tick();
        chk("mid_we3", memWe, 0);

        // Randomized traffic against the transaction-level model.
        do_reset(16'hFFFF, 16'h0000);
        for (int w = 0; w < 16; w++) ref_mem[w] = mem[w];
        exp_q.delete();
        lg_eng = 1; last_rmw = -10; rd_last = 0; disp_exp = '0;
        for (int i = 0; i < 3000; i++) begin
            s_p = pixReq; s_pa = pixAddr; s_pd = pixData;
            s_e = engReq; s_w = engWrite; s_ea = engAddr; s_ed = engWData;
            if (cyc % 2 == 0) disp_exp = mem[dispAddr];
            tick();
            exp_p = 0; exp_e = 0;
            if (cyc % 2 == 1 && (cyc - last_rmw) != 2) begin
                if (s_p && (!s_e || lg_eng)) exp_p = 1;
                else if (s_e) exp_e = 1;
            end
            chk("rnd_pix_ack", pixAck, exp_p);
            chk("rnd_eng_ack", engAck, exp_e);
            chk("rnd_disp_valid", dispValid, 32'(cyc % 2 == 1));
            if (cyc % 2 == 1) chk("rnd_disp_data", dispData, disp_exp);
            else chk("rnd_disp_we", memWe, 0);
            chk("rnd_rvalid", engRValid, rd_last);
            if (rd_last && exp_q.size() > 0) chk("rnd_rdata", engRData, exp_q.pop_front());
            rd_last = exp_e && !s_w;
            if (exp_p) begin
                lg_eng = 0;
                if (s_pa < 19'd307200) begin
                    ref_mem[s_pa[6:3]][2*s_pa[2:0] +: 2] = s_pd;
                    last_rmw = cyc;
                end
            end
            if (exp_e) begin
                lg_eng = 1;
                if (s_w) ref_mem[s_ea[3:0]] = s_ed;
                else exp_q.push_back(ref_mem[s_ea[3:0]]);
            end
            dispAddr = 16'($urandom_range(0, 15));
            if (i < 2980) begin
                if (exp_p || !pixReq) begin
                    pixReq  = ($urandom_range(0, 2) != 0);
                    pixAddr = ($urandom_range(0, 7) == 0) ? 19'(307200 + $urandom_range(0, 1000))
                                                          : 19'($urandom_range(0, 127));
                    pixData = 2'($urandom_range(0, 3));
                end
                if (exp_e || !engReq) begin
                    engReq   = ($urandom_range(0, 2) != 0);
                    engWrite = 1'($urandom_range(0, 1));
                    engAddr  = 16'($urandom_range(0, 15));
                    engWData = 16'($urandom);
                end
            end else begin
                pixReq = 0;
                engReq = 0;
            end
        end
        for (int w = 0; w < 16; w++) chk("rnd_mem", mem[w], ref_mem[w]);
        chk("rnd_reads_left", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/frame_buffer_arbiter.md
Name: frame_buffer_arbiter

Overview:
Time-slot scheduler and arbiter for the packed 2-bit-per-pixel SPRAM frame buffer (640x480, 8 pixels per 16-bit word, 4 SP256K banks).
- Guarantees the VGA display path two fixed read slots in every 4-cycle round.
- Shares the remaining two slots round-robin between the SPI pixel loader (single-pixel writes, done as read-modify-write) and the edge-detection engine (whole-word reads and writes).
- Drives one word-wide memory command port into the bank wrapper.

Parameters:
ADDR_W, 16, word address width (bank select = top 2 bits)
DATA_W, 16, memory word width
NUM_PIXELS, 307200, pixel addresses >= this are accepted and discarded

Ports:
mainClk in 1 system clock
reset in 1 asynchronous, active-high reset
dispAddr in ADDR_W display word address, sampled in display slots
dispData out DATA_W display read word
dispValid out 1 dispData valid this cycle
pixReq in 1 loader has a pixel pending (level, held until pixAck)
pixAddr in 19 pixel address
pixData in 2 pixel value
pixAck out 1 one-cycle pulse: pixel accepted
engReq in 1 engine request pending (held until engAck)
engWrite in 1 1 = write, 0 = read
engAddr in ADDR_W engine word address
engWData in DATA_W engine write word
engAck out 1 one-cycle pulse: engine request accepted
engRData out DATA_W engine read word
engRValid out 1 engRData valid this cycle
memAddr out ADDR_W memory word address
memWData out DATA_W memory write word
memWe out 1 memory write enable
memMask out 4 nibble write mask, always 4'b1111 when memWe=1
memRData in DATA_W memory read word, valid 1 cycle after the read is issued

Behaviour:
- phase: 2-bit free-running counter. Reset value 0; increments every cycle and wraps 3 -> 0.
- Display slots are phases 0 and 2:
  - memAddr=dispAddr, memWe=0.
  - In the next cycle (phase 1 or 3): dispValid=1 and dispData=memRData.
  - dispValid is never asserted at phase 0 or 2.
- Client slots are phases 1 and 3. Client FSM states: IDLE, PIX_RD, PIX_WAIT, PIX_WR.
- Grant (IDLE, client slot):
  - With only one requester, that requester is granted.
  - With both requesting, grant goes to the one not granted last (lastGrant register). Reset value of lastGrant = ENG, so the pixel loader wins the first tie.
  - With neither requesting, memWe=0 and memAddr=0.
- Engine grant:
  - engAck=1 in the grant cycle; memAddr=engAddr.
  - Write: memWe=1, memWData=engWData.
  - Read: memWe=0; next cycle engRValid=1 with engRData=memRData.
  - FSM stays IDLE.
- Pixel grant (cycle t, client slot):
  - pixAck=1; latch pixAddr and pixData; memAddr=pixAddr[18:3], memWe=0.
  - Go to PIX_WAIT.
- PIX_WAIT (t+1, display slot):
  - The display read proceeds normally.
  - mergeBuf <= memRData with bits [2k+1:2k] replaced by the latched pixel, where k=pixAddr[2:0].
  - Go to PIX_WR.
- PIX_WR (t+2, client slot):
  - memAddr=latched word address, memWData=mergeBuf, memWe=1.
  - Go to IDLE; lastGrant=PIX.
  - No other client is granted while in PIX_WAIT or PIX_WR, so no RMW hazard.
- Out-of-range pixel (pixAddr >= NUM_PIXELS):
  - pixAck=1 and lastGrant=PIX, but no memory access; FSM stays IDLE.
  - The slot goes unused (no re-grant in the same cycle).
- Memory-port outputs are combinational from the registered phase/state/buffers. All other outputs are registered.
- Reset value of every registered output is 0 (dispData, dispValid, engRData, engRValid, pixAck, engAck).
- Reset mid-RMW: the FSM returns to IDLE and the pending write is abandoned. memWe must not rise in the cycle after reset deasserts unless a new engine write is granted. The loader's pixel counts as accepted (pixAck was already issued) and is lost.
- Requests that drop before an ack are legal; they are simply not granted.

Decomposition:
- fb_arb_pkg holds:
  - clientState_t enum {IDLE, PIX_RD, PIX_WAIT, PIX_WR}
  - grant_t enum {PIX, ENG}
  - phase constants PH_DISP0=0, PH_CLI0=1, PH_DISP1=2, PH_CLI1=3
  - NUM_PIXELS default
- One sub-module: pixel_merge (word, 3-bit index, 2-bit pixel -> merged word). It is shared with future writers.

Test Plan:
- Display only: no client requests, dispAddr=16'h0010, memory model returns 16'hA5A5 -> dispValid pulses at phases 1 and 3 with dispData=16'hA5A5; memWe stays 0 throughout.
- Pixel RMW: memory word 0x0002 = 16'hFFFF; pixReq with pixAddr=19'd21 (word 2, k=5), pixData=2'b00 -> pixAck at phase 1; two cycles later memWe=1, memAddr=2, memWData=16'hF3FF.
- Engine round trip: engine writes 16'h1234 to addr 7, then reads addr 7 -> engAck twice; engRValid one cycle after the read slot with engRData=16'h1234.
- Contention: pixReq and engReq both held from reset -> grant order PIX, ENG, PIX, ENG. The engine is never granted during PIX_WAIT or PIX_WR; the display slots are never displaced.
- Out of range: pixAddr=19'd307200 -> pixAck=1, no memWe over the next 4 cycles, FSM stays IDLE.
- Reset mid-RMW: assert reset in PIX_WAIT -> after release memWe=0 and phase=0, FSM IDLE, all outputs 0; a following engine read completes normally.
